otter_io_responder: RTL and testbench

Memory-mapped I/O responder on the far end of the OTTER CPU's IOBUS. It decodes the CPU's IOBUS_ADDR/IOBUS_OUT/IOBUS_WR traffic in the 0x1100_0000 region and returns registered read data on IOBUS_IN one cycle later, matching the synchronous MEM-stage read of the pipelined core. It hosts a switch input port, an LED output register and a programmable down-counting timer that drives the CPU's INTR line.

---
 rtl/otter_io_pkg.sv | 29 ++
 rtl/otter_io_timer.sv | 80 ++++++++
 rtl/otter_io_responder.sv | 94 +++++++++
 tb/tb_otter_io_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// Shared constants and types for the OTTER IOBUS responder and its timer.
// The timer is compiled in only when OTTER_IO_TIMER_EN is defined.
package otter_io_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1100_0000;

  localparam logic [7:0] OFF_SW         = 8'h00;
  localparam logic [7:0] OFF_LED        = 8'h20;
  localparam logic [7:0] OFF_TMR_CTRL   = 8'h40;
  localparam logic [7:0] OFF_TMR_COUNT  = 8'h44;
  localparam logic [7:0] OFF_TMR_RELOAD = 8'h48;
  localparam logic [7:0] OFF_TMR_STATUS = 8'h4C;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_WIDTH       = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  // Word-aligned offset within the 256-byte region; byte lanes are ignored.
  function automatic logic [7:0] word_offset(input logic [31:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_io_timer.sv
// Programmable down-counting timer with auto-reload and a level interrupt.
// Instantiated by otter_io_responder only when OTTER_IO_TIMER_EN is defined.
module otter_io_timer
  import otter_io_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_ctrl,
  input  logic                  wr_count,
  input  logic                  wr_reload,
  input  logic                  wr_status,
  input  logic [31:0]           wdata,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [31:0]           count,
  output logic [31:0]           reload,
  output logic                  expired,
  output logic                  intr
);

  timer_state_t          state_reg;
  logic [CTRL_WIDTH-1:0] ctrl_reg;
  logic [31:0]           count_reg;
  logic [31:0]           reload_reg;
  logic                  expired_reg;

  logic running;
  logic stop_write;
  logic expire_now;

  assign running    = (state_reg == RUN);
  assign stop_write = wr_ctrl && !wdata[CTRL_EN];
  // A CPU store to COUNT pre-empts the whole countdown step, including expiry.
  assign expire_now = running && (count_reg == 32'd0) && !wr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ctrl_reg    <= '0;
      count_reg   <= '0;
      reload_reg  <= '0;
      expired_reg <= 1'b0;
    end else begin
      if (wr_reload) begin
        reload_reg <= wdata;
      end

      // A fresh expiry wins over a simultaneous W1C.
      if (expire_now) begin
        expired_reg <= 1'b1;
      end else if (wr_status && wdata[0]) begin
        expired_reg <= 1'b0;
      end

      if (wr_count) begin
        count_reg <= wdata;
      end else if (running && !stop_write) begin
        if (count_reg != 32'd0) begin
          count_reg <= count_reg - 32'd1;
        end else if (ctrl_reg[CTRL_AUTO_RELOAD]) begin
          count_reg <= reload_reg;
        end
      end

      if (wr_ctrl) begin
        ctrl_reg  <= wdata[CTRL_WIDTH-1:0];
        state_reg <= wdata[CTRL_EN] ? RUN : IDLE;
      end else if (expire_now && !ctrl_reg[CTRL_AUTO_RELOAD]) begin
        ctrl_reg[CTRL_EN] <= 1'b0;
        state_reg         <= IDLE;
      end
    end
  end

  assign ctrl    = ctrl_reg;
  assign count   = count_reg;
  assign reload  = reload_reg;
  assign expired = expired_reg;
  assign intr    = expired_reg & ctrl_reg[CTRL_IRQ_EN];

endmodule

// File: rtl/otter_io_responder.sv
// OTTER IOBUS responder: switch port, LED register and optional timer with
// registered one-cycle read data. Timer is present when OTTER_IO_TIMER_EN is defined.
module otter_io_responder
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          SW_WIDTH  = 16,
  parameter int          LED_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic                 INTR
);

  logic                 hit;
  logic [7:0]           offset;
  logic                 wr_hit;
  logic [SW_WIDTH-1:0]  sw_meta_reg;
  logic [SW_WIDTH-1:0]  sw_sync_reg;
  logic [LED_WIDTH-1:0] led_reg;
  logic [31:0]          rdata_next;
  logic [31:0]          rdata_reg;

  assign hit    = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
  assign offset = word_offset(IOBUS_ADDR);
  assign wr_hit = IOBUS_WR && hit;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      led_reg     <= '0;
      rdata_reg   <= '0;
    end else begin
      sw_meta_reg <= SWITCHES;
      sw_sync_reg <= sw_meta_reg;
      if (wr_hit && (offset == OFF_LED)) begin
        led_reg <= IOBUS_OUT[LED_WIDTH-1:0];
      end
      rdata_reg <= rdata_next;
    end
  end

  assign LEDS     = led_reg;
  assign IOBUS_IN = rdata_reg;

`ifdef OTTER_IO_TIMER_EN
  logic [CTRL_WIDTH-1:0] tmr_ctrl;
  logic [31:0]           tmr_count;
  logic [31:0]           tmr_reload;
  logic                  tmr_expired;

  otter_io_timer u_timer (
    .clk       (CLK),
    .rst       (RESET),
    .wr_ctrl   (wr_hit && (offset == OFF_TMR_CTRL)),
    .wr_count  (wr_hit && (offset == OFF_TMR_COUNT)),
    .wr_reload (wr_hit && (offset == OFF_TMR_RELOAD)),
    .wr_status (wr_hit && (offset == OFF_TMR_STATUS)),
    .wdata     (IOBUS_OUT),
    .ctrl      (tmr_ctrl),
    .count     (tmr_count),
    .reload    (tmr_reload),
    .expired   (tmr_expired),
    .intr      (INTR)
  );
`else
  assign INTR = 1'b0;
`endif

  always_comb begin
    rdata_next = '0;
    if (hit) begin
      case (offset)
        OFF_SW:         rdata_next[SW_WIDTH-1:0]   = sw_sync_reg;
        OFF_LED:        rdata_next[LED_WIDTH-1:0]  = led_reg;
`ifdef OTTER_IO_TIMER_EN
        OFF_TMR_CTRL:   rdata_next[CTRL_WIDTH-1:0] = tmr_ctrl;
        OFF_TMR_COUNT:  rdata_next                 = tmr_count;
        OFF_TMR_RELOAD: rdata_next                 = tmr_reload;
        OFF_TMR_STATUS: rdata_next[0]              = tmr_expired;
`endif
        default:        rdata_next                 = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_io_responder.sv
// Self-checking bench for otter_io_responder: register-map vector table,
// switch synchronizer latency, timer sequences (when OTTER_IO_TIMER_EN) and mid-run reset.
module tb_otter_io_responder;

  localparam logic [31:0] B        = 32'h1100_0000;
  localparam logic [31:0] A_SW     = B + 32'h00;
  localparam logic [31:0] A_LED    = B + 32'h20;
  localparam logic [31:0] A_CTRL   = B + 32'h40;
  localparam logic [31:0] A_COUNT  = B + 32'h44;
  localparam logic [31:0] A_RELOAD = B + 32'h48;
  localparam logic [31:0] A_STATUS = B + 32'h4C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        intr;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_leds;
  } vec_t;

  typedef struct {
    bit          chk;
    logic [31:0] val;
    string       name;
  } sb_t;

  vec_t vecs[15];
  sb_t  sb_q[$];

  otter_io_responder dut (
    .CLK        (clk),
    .RESET      (reset),
    .IOBUS_ADDR (iobus_addr),
    .IOBUS_OUT  (iobus_out),
    .IOBUS_WR   (iobus_wr),
    .IOBUS_IN   (iobus_in),
    .SWITCHES   (switches),
    .LEDS       (leds),
    .INTR       (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One bus cycle; the expected read value is queued at drive time and
  // compared after the edge that captures it.
  task automatic drive(input string name, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input bit chk, input logic [31:0] exp);
    sb_t e;
    e.chk  = chk;
    e.val  = exp;
    e.name = name;
    iobus_addr = a;
    iobus_wr   = w;
    iobus_out  = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    iobus_wr = 1'b0;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (e.chk) check(e.name, iobus_in, e.val);
      else $display("txn  %s addr=%h wr=%b data=%h", name, a, w, d);
    end
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
    drive(name, a, 1'b1, d, 1'b0, 32'd0);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(name, a, 1'b0, 32'd0, 1'b1, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{A_LED,             1'b1, 32'h0000_A5A5, 32'h0000_0000, 16'hA5A5};
    vecs[1]  = '{A_LED,             1'b0, 32'h0,         32'h0000_A5A5, 16'hA5A5};
    vecs[2]  = '{A_LED,             1'b1, 32'hFFFF_1234, 32'h0000_A5A5, 16'h1234};
    vecs[3]  = '{A_LED,             1'b0, 32'h0,         32'h0000_1234, 16'h1234};
    vecs[4]  = '{B + 32'h10,        1'b1, 32'h0000_DEAD, 32'h0000_0000, 16'h1234};
    vecs[5]  = '{B + 32'h10,        1'b0, 32'h0,         32'h0000_0000, 16'h1234};
    vecs[6]  = '{32'h1200_0020,     1'b1, 32'h0000_BEEF, 32'h0000_0000, 16'h1234};
    vecs[7]  = '{B + 32'h23,        1'b0, 32'h0,         32'h0000_1234, 16'h1234};
    vecs[8]  = '{B + 32'h22,        1'b1, 32'h0000_0055, 32'h0000_1234, 16'h0055};
    vecs[9]  = '{A_SW,              1'b0, 32'h0,         32'h0000_0000, 16'h0055};
    vecs[10] = '{A_CTRL,            1'b0, 32'h0,         32'h0000_0000, 16'h0055};
    vecs[11] = '{B + 32'hFC,        1'b0, 32'h0,         32'h0000_0000, 16'h0055};
    vecs[12] = '{32'h1100_0120,     1'b0, 32'h0,         32'h0000_0000, 16'h0055};
    vecs[13] = '{A_SW,              1'b1, 32'h0000_FFFF, 32'h0000_0000, 16'h0055};
    vecs[14] = '{A_SW,              1'b0, 32'h0,         32'h0000_0000, 16'h0055};

    reset      = 1'b1;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    switches   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iobus_in", iobus_in, 32'd0);
    check("rst_leds", {16'd0, leds}, 32'd0);
    check("rst_intr", {31'd0, intr}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b1, vecs[i].exp_rd);
      check($sformatf("vec%0d_leds", i), {16'd0, leds}, {16'd0, vecs[i].exp_leds});
    end

    // Switch change is visible on IOBUS_IN on the third edge.
    switches = 16'h1234;
    rd("sw_edge1", A_SW, 32'h0);
    rd("sw_edge2", A_SW, 32'h0);
    rd("sw_edge3", A_SW, 32'h0000_1234);
    rd("unmapped_10", B + 32'h10, 32'h0);

`ifdef OTTER_IO_TIMER_EN
    // One-shot: COUNT=3, EN|IRQ_EN -> expiry on edge 4.
    wr("t1_count", A_COUNT, 32'd3);
    wr("t1_ctrl", A_CTRL, 32'h5);
    for (int i = 0; i < 4; i++) begin
      rd($sformatf("t1_count_e%0d", i + 1), A_COUNT, 32'(3 - i));
      check($sformatf("t1_intr_e%0d", i + 1), {31'd0, intr}, {31'd0, i == 3});
    end
    rd("t1_ctrl_en_cleared", A_CTRL, 32'h4);
    rd("t1_status", A_STATUS, 32'h1);
    rd("t1_count_holds0", A_COUNT, 32'h0);
    wr("t1_w1c", A_STATUS, 32'h1);
    check("t1_intr_cleared", {31'd0, intr}, 32'd0);
    rd("t1_status_cleared", A_STATUS, 32'h0);

    // Auto-reload: RELOAD=2 gives an expiry every 3 edges.
    wr("t2_reload", A_RELOAD, 32'd2);
    wr("t2_count", A_COUNT, 32'd2);
    wr("t2_ctrl", A_CTRL, 32'h7);
    rd("t2_count_e1", A_COUNT, 32'd2);  check("t2_intr_e1", {31'd0, intr}, 32'd0);
    rd("t2_count_e2", A_COUNT, 32'd1);  check("t2_intr_e2", {31'd0, intr}, 32'd0);
    rd("t2_count_e3", A_COUNT, 32'd0);  check("t2_intr_e3", {31'd0, intr}, 32'd1);
    wr("t2_w1c_e4", A_STATUS, 32'h1);   check("t2_intr_e4", {31'd0, intr}, 32'd0);
    rd("t2_count_e5", A_COUNT, 32'd1);  check("t2_intr_e5", {31'd0, intr}, 32'd0);
    rd("t2_count_e6", A_COUNT, 32'd0);  check("t2_intr_e6", {31'd0, intr}, 32'd1);
    wr("t2_w1c_e7", A_STATUS, 32'h1);   check("t2_intr_e7", {31'd0, intr}, 32'd0);
    rd("t2_count_e8", A_COUNT, 32'd1);  check("t2_intr_e8", {31'd0, intr}, 32'd0);
    wr("t2_w1c_e9", A_STATUS, 32'h1);   check("t2_expiry_beats_w1c", {31'd0, intr}, 32'd1);
    wr("t2_stop", A_CTRL, 32'h0);
    rd("t2_count_held", A_COUNT, 32'd2);
    rd("t2_count_still", A_COUNT, 32'd2);
    wr("t2_w1c_final", A_STATUS, 32'h1);
    check("t2_intr_final", {31'd0, intr}, 32'd0);

    // COUNT write on the edge that would reach 0 wins over the decrement.
    wr("t3_count", A_COUNT, 32'd2);
    wr("t3_ctrl", A_CTRL, 32'h5);
    rd("t3_count_e1", A_COUNT, 32'd2);
    drive("t3_count_wr9", A_COUNT, 1'b1, 32'd9, 1'b1, 32'd1);
    rd("t3_count_9", A_COUNT, 32'd9);
    rd("t3_count_8", A_COUNT, 32'd8);
    check("t3_no_intr", {31'd0, intr}, 32'd0);
    rd("t3_status", A_STATUS, 32'h0);
    wr("t3_stop", A_CTRL, 32'h0);

    // EN cleared by the CPU on the expiry edge still records the expiry.
    wr("t4_count", A_COUNT, 32'd0);
    wr("t4_ctrl", A_CTRL, 32'h5);
    wr("t4_disable", A_CTRL, 32'h4);
    check("t4_intr", {31'd0, intr}, 32'd1);
    rd("t4_status", A_STATUS, 32'h1);
    rd("t4_ctrl", A_CTRL, 32'h4);

    wr("t5_count", A_COUNT, 32'h50);
    wr("t5_ctrl", A_CTRL, 32'h7);
    check("t5_intr_pre", {31'd0, intr}, 32'd1);
`else
    wr("nt_ctrl", A_CTRL, 32'h5);
    wr("nt_count", A_COUNT, 32'd3);
    rd("nt_count", A_COUNT, 32'h0);
    rd("nt_ctrl", A_CTRL, 32'h0);
    rd("nt_status", A_STATUS, 32'h0);
    check("nt_intr", {31'd0, intr}, 32'd0);
`endif

    // Asynchronous reset between edges clears outputs immediately.
    rd("pre_reset_led", A_LED, 32'h0000_0055);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_iobus_in", iobus_in, 32'd0);
    check("async_rst_leds", {16'd0, leds}, 32'd0);
    check("async_rst_intr", {31'd0, intr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd("post_rst_count", A_COUNT, 32'h0);
    rd("post_rst_ctrl", A_CTRL, 32'h0);
    rd("post_rst_led", A_LED, 32'h0);
    check("post_rst_intr", {31'd0, intr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
